uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Round-robin arbiter that shares the single UART_TX serialiser between NREQ byte producers
//  (e.g. INTF result path, debug/status sources). It accepts one byte per valid/ready handshake,
//  drives UART_TX's i_data_byte/i_tx_signal, and waits for UART_TX o_done_bit before granting
//  the next requester. It sits between the producer blocks and UART_TX in the top level.
// PARAMETERS
//  NREQ          4     number of requesters (2..8)
//  SIZEDATA      8     byte width
//  SIG_HOLD      1     clocks o_tx_signal is held high per byte (>=1; set >= one tick period if TX samples on ticks)
//  TIMEOUT_CYC   2000000  clocks allowed in WAIT before abort (only with UART_ARB_TIMEOUT_EN)
// PORTS
//  i_clock       in   1              system clock
//  i_reset       in   1              synchronous, active-high reset
//  i_req_valid   in   NREQ           per-requester byte valid; must hold stable with data until ready
//  i_req_data    in   NREQ*SIZEDATA  requester k data in bits [k*SIZEDATA +: SIZEDATA]
//  o_req_ready   out  NREQ           one-hot, 1-cycle accept pulse to granted requester
//  o_tx_data_byte out SIZEDATA       byte to UART_TX i_data_byte
//  o_tx_signal   out  1              start strobe to UART_TX i_tx_signal
//  i_tx_done     in   1              UART_TX o_done_bit (1-cycle pulse at end of frame)
//  o_grant_id    out  $clog2(NREQ)   index of requester currently owning TX
//  o_busy        out  1              high in every state except IDLE
//  o_timeout     out  1              1-cycle pulse on watchdog abort (0 when feature disabled)
// BEHAVIOUR
//  - Reset: state=IDLE, rr_ptr=0, all outputs 0, hold counter 0, watchdog 0. Reset mid-frame
//    drops o_tx_signal next edge; UART_TX is reset by the same i_reset.
//  - FSM IDLE -> SEND -> WAIT -> IDLE.
//  - IDLE: if |i_req_valid, pick first k with valid[k]=1 searching rr_ptr, rr_ptr+1, ... mod NREQ.
//    Same edge: o_req_ready[k]<=1 (one cycle), o_tx_data_byte<=data[k], o_grant_id<=k,
//    hold counter<=SIG_HOLD-1, state<=SEND. No valid -> stay, outputs unchanged.
//  - SEND: o_tx_signal=1; counter decrements; at 0 -> o_tx_signal<=0, state<=WAIT.
//    Latency valid->o_tx_signal high: 2 clocks (registered).
//  - WAIT: on i_tx_done=1 -> rr_ptr<=(grant_id+1) mod NREQ, state<=IDLE. Next grant evaluated
//    in IDLE the following cycle, so back-to-back bytes have >=1 idle clock between frames.
//  - i_tx_done in IDLE or SEND: ignored (no state change, no pointer update).
//  - o_tx_data_byte held stable from grant until next grant (UART_TX may sample late).
//  - Requester dropping valid before ready: allowed, no byte taken. Valid never drops after ready.
//  - Only one o_req_ready bit high at any time; rr_ptr advances only on completed/aborted frame.
//  - NREQ not power of two: pointer wraps at NREQ-1 -> 0, never indexes >= NREQ.
// CONFIGURATION
//  UART_ARB_TIMEOUT_EN defined: watchdog counts clocks in WAIT; reaching TIMEOUT_CYC-1 without
//    i_tx_done -> o_timeout 1-cycle pulse, rr_ptr advances as on done, state<=IDLE. Counter
//    clears on entering WAIT.
//  Not defined: no counter logic; o_timeout tied 0; WAIT waits indefinitely for i_tx_done.
// TESTING
//  1 Reset: hold i_reset 3 clk with valid=4'b1111 -> ready=0, o_tx_signal=0, o_busy=0, grant_id=0.
//  2 Single req: valid[2]=1, data=8'h06 -> ready[2] pulse, o_tx_data_byte=8'h06, o_tx_signal
//    high SIG_HOLD clk after 2 clk; UART_TX serialises 0x06; busy drops 1 clk after i_tx_done.
//  3 Round robin: all 4 valid continuously, data k=8'h10+k -> grant order 0,1,2,3,0; bytes
//    10,11,12,13,10 on serial line; no requester granted twice while another waits.
//  4 Stray done: pulse i_tx_done in IDLE and in SEND -> no state/pointer change, frame completes.
//  5 Reset mid-frame: assert i_reset during WAIT of requester 1 -> IDLE, rr_ptr=0, o_tx_data line
//    idles high; next grant with valid=4'b0011 goes to 0.
//  6 With UART_ARB_TIMEOUT_EN, TIMEOUT_CYC=100, i_tx_done forced 0 -> o_timeout pulse 100 clk
//    after entering WAIT, next pending requester granted; without macro o_timeout stays 0.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundles the producer handshake and the UART_TX control/status signals seen
// by uart_tx_arbiter.
//   req_valid    [NREQ]           per-requester byte valid
//   req_data     [NREQ*SIZEDATA]  requester k byte in [k*SIZEDATA +: SIZEDATA]
//   req_ready    [NREQ]           one-hot accept pulse to the granted requester
//   tx_data_byte [SIZEDATA]       byte presented to UART_TX
//   tx_signal                     start strobe to UART_TX
//   tx_done                       end-of-frame pulse from UART_TX
//   grant_id     [$clog2(NREQ)]   requester currently owning TX
//   busy                          arbiter not idle
//   timeout                       watchdog abort pulse
// Modports: master = producers/UART_TX side, slave = arbiter.
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
  parameter int NREQ     = 4,
  parameter int SIZEDATA = 8
);
  localparam int GW = $clog2(NREQ);

  logic [NREQ-1:0]          req_valid;
  logic [NREQ*SIZEDATA-1:0] req_data;
  logic [NREQ-1:0]          req_ready;
  logic [SIZEDATA-1:0]      tx_data_byte;
  logic                     tx_signal;
  logic                     tx_done;
  logic [GW-1:0]            grant_id;
  logic                     busy;
  logic                     timeout;

  modport master (
    output req_valid, req_data, tx_done,
    input  req_ready, tx_data_byte, tx_signal, grant_id, busy, timeout
  );

  modport slave (
    input  req_valid, req_data, tx_done,
    output req_ready, tx_data_byte, tx_signal, grant_id, busy, timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin arbiter sharing one UART_TX serialiser between NREQ byte
// producers. One byte is accepted per valid/ready handshake, the start strobe
// is held for SIG_HOLD clocks, then the arbiter waits for UART_TX's done pulse
// before the next grant.
// Ports:
//   i_clock  system clock
//   i_reset  synchronous, active-high reset
//   bus      uart_tx_arbiter_if.slave (handshake, TX control and status)
// Optional feature: define UART_ARB_TIMEOUT_EN to enable a WAIT watchdog of
// TIMEOUT_CYC clocks; otherwise timeout is tied low and WAIT is unbounded.
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NREQ        = 4,
  parameter int SIZEDATA    = 8,
  parameter int SIG_HOLD    = 1,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic               i_clock,
  input  logic               i_reset,
  uart_tx_arbiter_if.slave   bus
);
  localparam int GW = $clog2(NREQ);
  localparam int HW = (SIG_HOLD > 1) ? $clog2(SIG_HOLD) : 1;
  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  // Elaboration-time parameter range checks
  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("uart_tx_arbiter: NREQ must be 2..8");
  end
  if (SIG_HOLD < 1 || TIMEOUT_CYC < 2) begin : g_bad_timing
    $error("uart_tx_arbiter: SIG_HOLD must be >= 1 and TIMEOUT_CYC >= 2");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, WAIT = 2'd2} state_t;

  state_t              state_r, state_next;
  logic [GW-1:0]       rr_ptr_r, rr_ptr_next;
  logic [NREQ-1:0]     req_ready_r, req_ready_next;
  logic [SIZEDATA-1:0] data_r, data_next;
  logic                tx_sig_r, tx_sig_next;
  logic [GW-1:0]       grant_r, grant_next;
  logic [HW-1:0]       hold_r, hold_next;
  logic                busy_r;
  logic                found;
  logic [GW-1:0]       sel;
  logic [GW:0]         cand;
  logic [GW-1:0]       ptr_after;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYC);
  logic [WW-1:0]       wd_r, wd_next;
  logic                timeout_r, timeout_next;
`endif

  // Pointer value after a finished or aborted frame, wrapping at NREQ-1
  assign ptr_after = (grant_r == GW'(NREQ - 1)) ? '0 : grant_r + GW'(1);

  // Next-state, round-robin search and next register values
  always_comb begin
    state_next     = state_r;
    rr_ptr_next    = rr_ptr_r;
    req_ready_next = '0;
    data_next      = data_r;
    tx_sig_next    = tx_sig_r;
    grant_next     = grant_r;
    hold_next      = hold_r;
    found          = 1'b0;
    sel            = rr_ptr_r;
    cand           = '0;
`ifdef UART_ARB_TIMEOUT_EN
    wd_next        = wd_r;
    timeout_next   = 1'b0;
`endif

    // First valid requester at or after rr_ptr, modulo NREQ
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, rr_ptr_r} + (GW+1)'(i);
      if (cand >= (GW+1)'(NREQ)) begin
        cand = cand - (GW+1)'(NREQ);
      end else begin
        cand = cand;
      end
      if (!found && bus.req_valid[cand[GW-1:0]]) begin
        found = 1'b1;
        sel   = cand[GW-1:0];
      end else begin
        found = found;
      end
    end

    case (state_r)
      IDLE: begin
        if (found) begin
          req_ready_next = ONE_HOT0 << sel;
          data_next      = bus.req_data[sel*SIZEDATA +: SIZEDATA];
          grant_next     = sel;
          hold_next      = HW'(SIG_HOLD - 1);
          state_next     = SEND;
        end else begin
          state_next = IDLE;
        end
      end
      SEND: begin
        // First SEND clock raises the strobe; hold_r then counts its length
        if (!tx_sig_r) begin
          tx_sig_next = 1'b1;
        end else if (hold_r == '0) begin
          tx_sig_next = 1'b0;
          state_next  = WAIT;
`ifdef UART_ARB_TIMEOUT_EN
          wd_next     = '0;
`endif
        end else begin
          hold_next = hold_r - HW'(1);
        end
      end
      WAIT: begin
        if (bus.tx_done) begin
          rr_ptr_next = ptr_after;
          state_next  = IDLE;
`ifdef UART_ARB_TIMEOUT_EN
        end else if (wd_r == WW'(TIMEOUT_CYC - 1)) begin
          timeout_next = 1'b1;
          rr_ptr_next  = ptr_after;
          state_next   = IDLE;
        end else begin
          wd_next = wd_r + WW'(1);
        end
`else
        end else begin
          state_next = WAIT;
        end
`endif
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_r     <= IDLE;
      rr_ptr_r    <= '0;
      req_ready_r <= '0;
      data_r      <= '0;
      tx_sig_r    <= 1'b0;
      grant_r     <= '0;
      hold_r      <= '0;
      busy_r      <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      wd_r        <= '0;
      timeout_r   <= 1'b0;
`endif
    end else begin
      state_r     <= state_next;
      rr_ptr_r    <= rr_ptr_next;
      req_ready_r <= req_ready_next;
      data_r      <= data_next;
      tx_sig_r    <= tx_sig_next;
      grant_r     <= grant_next;
      hold_r      <= hold_next;
      busy_r      <= (state_next != IDLE);
`ifdef UART_ARB_TIMEOUT_EN
      wd_r        <= wd_next;
      timeout_r   <= timeout_next;
`endif
    end
  end

  assign bus.req_ready    = req_ready_r;
  assign bus.tx_data_byte = data_r;
  assign bus.tx_signal    = tx_sig_r;
  assign bus.grant_id     = grant_r;
  assign bus.busy         = busy_r;
`ifdef UART_ARB_TIMEOUT_EN
  assign bus.timeout      = timeout_r;
`else
  assign bus.timeout      = 1'b0;
`endif
endmodule
